fht_transpose_8x8: RTL and testbench
====================================

# fht_transpose_8x8

Row-to-column transpose buffer for the 2-D FHT: it receives the serial 8-point 1-D FHT output stream of an 8×8 block, row by row, and re-emits the same 64 coefficients column by column. This stream is the input to the second (column) 1-D FHT pass. Double-buffered (ping-pong), so a continuous input stream is transposed without gaps or data loss. No backpressure is provided in either direction.

## Interface
- W, default 11 — sample width in bits; two's-complement signed.
- sclk  input  1  — clock; all state updates on rising edge.
- rst  input  1  — reset; synchronous and active-high.
- in_valid  input  1  — in_data carries a sample this cycle.
- in_data  input  W  — samples h(r,c) in row-major order: r=0..7, c=0..7, c fastest.
- out_valid  output  1  — out_data carries a sample this cycle.
- out_data  output  W  — samples h(r,c) in column-major order: c=0..7, r=0..7, r fastest.
- out_sof  output  1  — high with the first output sample, h(0,0), of each block.
- busy  output  1  — high while either bank holds unread or partially written data.

## Operation
- Storage is two banks, A and B, of 64×W bits each. Write pointer wbank and read pointer rbank both start at A.
- Each bank has a 2-bit state:
  - EMPTY → FILLING on the first write.
  - FILLING → FULL on the 64th write.
  - FULL → DRAINING when the reader starts.
  - DRAINING → EMPTY on the cycle the 64th read address is issued.
- Writer:
  - 6-bit counter wcnt, values 0..63; write address = wcnt = {r,c}.
  - Each in_valid writes in_data to wbank[wcnt], then increments wcnt.
  - At wcnt==63 the write also sets that bank to FULL, wraps wcnt to 0 and toggles wbank.
  - Gaps in in_valid of any length are allowed; the counter simply holds.
- Reader:
  - 6-bit counter rcnt; read address = {rcnt[2:0], rcnt[5:3]}, i.e. row = rcnt[2:0], column = rcnt[5:3].
  - Idle until bank rbank is FULL. It then issues 64 consecutive reads, one per cycle, with no gaps.
  - After the 64th read it toggles rbank. If the other bank is already FULL, its first read is issued on the very next cycle, giving seamless back-to-back output.
- At the maximum input rate (in_valid held high) a bank is always released before the writer returns to it. Sustained legal input never overflows, so no overflow detection is implemented.
- in_valid arriving while the target bank is FULL or DRAINING is a protocol violation. Behaviour is undefined. The bench flags it with an assertion.
- busy = (state of A ≠ EMPTY) | (state of B ≠ EMPTY).
- Reset mid-operation:
  - Both banks go to EMPTY; wbank, rbank, wcnt and rcnt go to 0.
  - out_valid, out_sof, out_data and busy go to 0 on the next edge.
  - Partial block contents are discarded; the memory array itself is not cleared.

## Timing
- Reset values: out_valid=0, out_sof=0, out_data=0, busy=0.
- The 64th sample of a block is captured at edge T. Bank goes FULL at T; first read address is registered at T+1.
- Output timing:
  - out_valid=1 and out_sof=1 with h(0,0) on cycle T+2.
  - out_valid stays high through T+65, carrying h(7,7) last.
  - Fixed latency: 2 cycles from FULL to first output.
- out_data is registered. It holds its last value while out_valid=0; only out_valid qualifies it.
- Back-to-back blocks at full rate: out_valid stays continuously high, and out_sof pulses every 64 cycles.
- Simultaneous write of the 64th sample into one bank and issue of the last read of the other bank is legal. Both state transitions take effect at the same edge.

## Configuration
- FHT_TRANSPOSE_SCALE_EN defined:
  - Output = (stored + 4) >>> 3, an arithmetic shift with round-half-up. This gives the 1/8 normalisation used for inverse transforms.
  - Result is sign-extended back to W bits.
  - One extra pipeline register is added, so first output moves to T+3 and every timing above shifts by +1.
- Not defined: output equals the stored value bit-exactly, with 2-cycle latency.

## Test plan
- Single block: in_valid held high, in_data = 8r+c for r,c = 0..7 → 64 contiguous outputs from T+2: 0,8,16,…,56,1,9,…,63; out_sof only on the first.
- Gapped input: 8-sample bursts separated by 6 idle cycles → same output ordering, 64 contiguous outputs starting 2 cycles after the last sample, busy falling after the final read.
- Three back-to-back blocks at full rate with distinct data → out_valid high for 192 cycles, no gaps, out_sof at offsets 0, 64 and 128, each block correctly transposed.
- Signed extremes: in_data alternating −1024 and +1023 (W=11) → exact values transposed. With FHT_TRANSPOSE_SCALE_EN: −128 and +128; +4 → +1, +3 → 0, −4 → 0.
- Reset asserted after 37 input samples, then a fresh block → no output from the partial block; new block is output correctly at T+2.
- Reset asserted during output, at output index 20 → out_valid=0 on the next edge; busy=0; subsequent blocks behave as after power-up.

Source files
------------

// File: rtl/fht_transpose_8x8_if.sv
// Stream bundle for the 8x8 FHT transpose buffer: row-major samples in, column-major samples out.
interface fht_transpose_8x8_if #(
    parameter int W = 11
);
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_sof;
    logic         busy;

    modport master (
        output in_valid, in_data,
        input  out_valid, out_data, out_sof, busy
    );

    modport slave (
        input  in_valid, in_data,
        output out_valid, out_data, out_sof, busy
    );
endinterface

// File: rtl/fht_transpose_8x8.sv
// Ping-pong 8x8 transpose buffer between the row and column 1-D FHT passes.
// Optional FHT_TRANSPOSE_SCALE_EN adds a rounded 1/8 output scale and one extra output stage.
module fht_transpose_8x8 #(
    parameter int W = 11
) (
    input  logic                 sclk,
    input  logic                 rst,
    fht_transpose_8x8_if.slave   bus
);
    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_st_t;

`ifdef FHT_TRANSPOSE_SCALE_EN
    localparam int STAGES = 2;
`else
    localparam int STAGES = 1;
`endif

    bank_st_t      st [2];
    logic          wbank, rbank;
    logic [5:0]    wcnt, rcnt;
    logic [W-1:0]  mem [128];
    logic [6:0]    rd_addr;
    logic [W-1:0]  rd_data;
    logic [STAGES:0] vld_pipe, sof_pipe;
    logic          rd_go;

    // The reader keeps issuing while its bank is FULL (first read) or DRAINING.
    assign rd_go = (st[rbank] == FULL) || (st[rbank] == DRAINING);

    always_ff @(posedge sclk) begin
        if (bus.in_valid)
            mem[{wbank, wcnt}] <= bus.in_data;
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            st[0]    <= EMPTY;
            st[1]    <= EMPTY;
            wbank    <= 1'b0;
            rbank    <= 1'b0;
            wcnt     <= '0;
            rcnt     <= '0;
            rd_addr  <= '0;
            vld_pipe <= '0;
            sof_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], rd_go};
            sof_pipe <= {sof_pipe[STAGES-1:0], rd_go && (rcnt == 6'd0)};
            if (bus.in_valid) begin
                wcnt <= wcnt + 6'd1;
                if (wcnt == 6'd63) begin
                    st[wbank] <= FULL;
                    wbank     <= ~wbank;
                end else if (st[wbank] == EMPTY) begin
                    st[wbank] <= FILLING;
                end
            end
            // Writer and reader never own the same bank, so both updates can land on one edge.
            if (rd_go) begin
                rd_addr <= {rbank, rcnt[2:0], rcnt[5:3]};
                rcnt    <= rcnt + 6'd1;
                if (rcnt == 6'd63) begin
                    st[rbank] <= EMPTY;
                    rbank     <= ~rbank;
                end else if (st[rbank] == FULL) begin
                    st[rbank] <= DRAINING;
                end
            end
        end
    end

    always_ff @(posedge sclk) begin
        if (rst)
            rd_data <= '0;
        else if (vld_pipe[0])
            rd_data <= mem[rd_addr];
    end

`ifdef FHT_TRANSPOSE_SCALE_EN
    logic signed [W:0] rnd, shr;
    logic [W-1:0]      scl_data;

    // One guard bit keeps +4 from overflowing before the arithmetic shift.
    assign rnd = {rd_data[W-1], rd_data} + (W+1)'(4);
    assign shr = rnd >>> 3;

    always_ff @(posedge sclk) begin
        if (rst)
            scl_data <= '0;
        else if (vld_pipe[1])
            scl_data <= shr[W-1:0];
    end

    assign bus.out_data = scl_data;
`else
    assign bus.out_data = rd_data;
`endif

    assign bus.out_valid = vld_pipe[STAGES];
    assign bus.out_sof   = sof_pipe[STAGES];
    assign bus.busy      = (st[0] != EMPTY) || (st[1] != EMPTY);
endmodule

// File: tb/tb_fht_transpose_8x8.sv
// Directed scoreboard bench for fht_transpose_8x8: each completed input block queues its transposed outputs.
module tb_fht_transpose_8x8;
    localparam int W = 11;
`ifdef FHT_TRANSPOSE_SCALE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic sclk = 1'b0;
    logic rst;
    always #5 sclk = ~sclk;

    fht_transpose_8x8_if #(.W(W)) bus ();
    fht_transpose_8x8 #(.W(W)) dut (.sclk(sclk), .rst(rst), .bus(bus));

    typedef struct {int data; bit sof; int cyc;} exp_t;
    exp_t q[$];
    int   lastq[$];
    int   blk[64];
    int   cyc = 0, n_cmp = 0, n_bad = 0, n_pop = 0, wcnt_m = 0;
    int   small_tab[8] = '{4, 3, -4, -5, 12, -12, 0, -1};

    always @(posedge sclk) cyc++;

    function automatic int expv(int s);
`ifdef FHT_TRANSPOSE_SCALE_EN
        return (s + 4) >>> 3;
`else
        return s;
`endif
    endfunction

    task automatic check(string tag, int obs, int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle; on the 64th valid sample queue the column-major expectation.
    task automatic step(input logic v, input int d);
        bus.in_valid = v;
        bus.in_data  = d[W-1:0];
        @(posedge sclk);
        #1;
        if (v) begin
            blk[wcnt_m] = d;
            wcnt_m++;
            if (wcnt_m == 64) begin
                for (int c = 0; c < 8; c++)
                    for (int r = 0; r < 8; r++)
                        q.push_back('{expv(blk[r*8+c]), (c == 0 && r == 0), cyc + LAT + c*8 + r});
                lastq.push_back(cyc + LAT + 63);
                wcnt_m = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge sclk);
        #1;
        q.delete();
        lastq.delete();
        wcnt_m = 0;
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_sof",   int'(bus.out_sof), 0);
        check("rst_out_data",  int'(bus.out_data), 0);
        check("rst_busy",      int'(bus.busy), 0);
        rst = 1'b0;
    endtask

    task automatic wait_drain(string tag);
        int k = 0;
        while (q.size() > 0 && k < 400) begin
            step(1'b0, 0);
            k++;
        end
        check({tag, "_drained"}, q.size(), 0);
        check({tag, "_busy_idle"}, int'(bus.busy), 0);
    endtask

    always @(negedge sclk) begin
        if (bus.out_valid) begin
            if (q.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                n_pop++;
                check("out_data", int'($signed(bus.out_data)), e.data);
                check("out_sof",  int'(bus.out_sof), int'(e.sof));
                check("out_cyc",  cyc, e.cyc);
            end
        end else begin
            if (bus.out_sof)
                check("sof_without_valid", 1, 0);
            if (q.size() > 0 && q[0].cyc <= cyc) begin
                check("missing_out", 0, 1);
                void'(q.pop_front());
            end
        end
        // A write captured on the next edge must find at most one bank still holding a block.
        if (bus.in_valid && !rst) begin
            while (lastq.size() > 0 && lastq[0] <= cyc + LAT - 1)
                void'(lastq.pop_front());
            n_cmp++;
            assert (lastq.size() < 2) else begin
                n_bad++;
                $error("FAIL overflow: observed %0d full banks expected below 2", lastq.size());
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, k;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        @(posedge sclk);
        #1;
        do_reset();

        // single block, full rate
        for (int i = 0; i < 64; i++) step(1'b1, i);
        check("blk1_busy", int'(bus.busy), 1);
        wait_drain("single");

        // 8-sample bursts with 6 idle cycles
        for (int b = 0; b < 8; b++) begin
            for (int c = 0; c < 8; c++) step(1'b1, 200 - (b*8 + c) * 3);
            if (b == 0) check("gap_busy", int'(bus.busy), 1);
            if (b < 7) idle(6);
        end
        wait_drain("gapped");

        // three back-to-back blocks
        for (int b = 0; b < 3; b++)
            for (int i = 0; i < 64; i++) step(1'b1, ((b*37 + i*5) % 2048) - 1024);
        wait_drain("b2b");

        // signed extremes then small rounding values
        for (int i = 0; i < 64; i++) step(1'b1, (i % 2) ? 1023 : -1024);
        for (int i = 0; i < 64; i++) step(1'b1, small_tab[i % 8]);
        wait_drain("signed");

        // reset after 37 samples discards the partial block
        for (int i = 0; i < 37; i++) step(1'b1, i + 500);
        do_reset();
        idle(3);
        for (int i = 0; i < 64; i++) step(1'b1, i*7 - 200);
        wait_drain("rst_partial");

        // reset during output
        for (int i = 0; i < 64; i++) step(1'b1, 100 - i*3);
        base = n_pop;
        k = 0;
        while (n_pop < base + 20 && k < 200) begin
            step(1'b0, 0);
            k++;
        end
        check("reach_idx20", n_pop - base, 20);
        do_reset();
        idle(5);
        for (int i = 0; i < 64; i++) step(1'b1, 1000 - i*31);
        wait_drain("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
